bus_ram_slave: RTL and testbench

Word-addressed scratchpad RAM that sits on one slave port (s0–s7) of the system bus interconnect and answers the CPU's bus master. It latches each request on `select_i`, inserts a fixed number of wait states, then performs the read or write and returns a single-cycle `ack_o` with registered read data. The bus routes `ack_o` combinationally back to the master and muxes `data_o` one cycle after select, so `data_o` is held stable after the ack.

---
 rtl/bus_ram_slave.sv | 98 +++++++++
 tb/tb_bus_ram_slave.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bus_ram_slave.sv
// Word-addressed scratchpad RAM slave: latches a request on select_i, waits
// WAIT_STATES cycles, then does the access and returns a one-cycle ack_o.
module bus_ram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic        select_i,
  output logic [31:0] data_o,
  output logic        ack_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_data;
  logic                  lat_we;

  logic                  go_ack;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_data;
  logic                  acc_we;

  // Decode is done by the bus, so the byte offset and high bits are dropped.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  // With zero wait states the ACK-entry edge is also the latch edge, so the
  // access must come straight from the bus inputs.
  always_comb begin
    go_ack   = 1'b0;
    acc_addr = lat_addr;
    acc_data = lat_data;
    acc_we   = lat_we;
    case (state)
      S_IDLE: if (select_i && WAIT_STATES == 0) begin
        go_ack   = 1'b1;
        acc_addr = addr_i[ADDR_WIDTH+1:2];
        acc_data = data_i;
        acc_we   = we_i;
      end
      S_WAIT: go_ack = select_i && (cnt == 4'd0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && go_ack && acc_we) mem[acc_addr] <= acc_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      lat_addr <= '0;
      lat_data <= 32'd0;
      lat_we   <= 1'b0;
      ack_o    <= 1'b0;
      data_o   <= 32'd0;
    end else begin
      ack_o <= 1'b0;
      if (go_ack) begin
        state <= S_ACK;
        ack_o <= 1'b1;
        if (!acc_we) data_o <= mem[acc_addr];
      end
      case (state)
        S_IDLE: if (select_i) begin
          lat_addr <= addr_i[ADDR_WIDTH+1:2];
          lat_data <= data_i;
          lat_we   <= we_i;
          if (WAIT_STATES != 0) begin
            cnt   <= CNT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A dropped select aborts even on the edge the count expires.
          if (!select_i)        state <= S_IDLE;
          else if (cnt != 4'd0) cnt   <= cnt - 4'd1;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ram_slave.sv
// Directed bench for bus_ram_slave: a transaction-level model predicts ack
// timing and read data every cycle, plus literal expectations per scenario.
module tb_bus_ram_slave;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i, addr_i, data_o;
  logic        we_i, select_i, ack_o;
  logic [31:0] z_data_i, z_addr_i, z_data_o;
  logic        z_we_i, z_select_i, z_ack_o;

  bus_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i),
    .select_i(select_i), .data_o(data_o), .ack_o(ack_o));

  bus_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .data_i(z_data_i), .addr_i(z_addr_i), .we_i(z_we_i),
    .select_i(z_select_i), .data_o(z_data_o), .ack_o(z_ack_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          we;
    int          word;
    logic [31:0] d;
  } txn_t;

  txn_t        q[$];
  logic [31:0] mem_m [int];
  logic [31:0] exp_data = 32'd0;
  int          ack_log[$];
  bit          chk_en = 1'b0;
  int          pass_cnt = 0;
  int          total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Outputs are registered, so the negedge sees them stable for the cycle.
  always @(negedge clk) begin : cmp
    bit ea;
    ea = 1'b0;
    if (chk_en) begin
      if (q.size() > 0 && q[0].at == cyc) begin
        ea = 1'b1;
        if (q[0].we) mem_m[q[0].word] = q[0].d;
        else         exp_data = mem_m[q[0].word];
        void'(q.pop_front());
        ack_log.push_back(cyc);
      end
      check("model_ack", {31'd0, ack_o}, {31'd0, ea});
      check("model_data", data_o, exp_data);
    end
  end

  // Called at a negedge; returns at the negedge where ack is visible,
  // select still high. b2b means issued during the previous ack cycle.
  task automatic req(input bit we, input logic [31:0] a, input logic [31:0] d, input bit b2b);
    txn_t t;
    addr_i = a; data_i = d; we_i = we; select_i = 1'b1;
    t.at = cyc + (b2b ? 2 : 1) + WS;
    t.we = we;
    t.word = int'((a >> 2) % 1024);
    t.d = d;
    q.push_back(t);
    repeat (WS + (b2b ? 2 : 1)) @(negedge clk);
  endtask

  task automatic idle();
    select_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req(1'b1, a, d, 1'b0);
    idle();
  endtask

  task automatic abort_req(input logic [31:0] a, input logic [31:0] d, input int n);
    addr_i = a; data_i = d; we_i = 1'b1; select_i = 1'b1;
    repeat (n) @(negedge clk);
    select_i = 1'b0;
    repeat (WS + 2) @(negedge clk);
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    select_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; data_i = 32'd0;
    z_select_i = 1'b0; z_we_i = 1'b0; z_addr_i = 32'd0; z_data_i = 32'd0;
    #1 rst = 1'b0;
    #1;
    check("reset_ack", {31'd0, ack_o}, 32'd0);
    check("reset_data", data_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // write then read, latency pinned to E0+WS+1
    c0 = cyc;
    req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    check("wr_latency", cyc - c0, 32'd3);
    check("wr_ack", {31'd0, ack_o}, 32'd1);
    idle();
    check("wr_ack_one_cycle", {31'd0, ack_o}, 32'd0);
    req(1'b0, 32'h10, 32'd0, 1'b0);
    check("rd_data", data_o, 32'hDEADBEEF);
    idle();
    check("rd_data_held", data_o, 32'hDEADBEEF);

    // alias and byte offset: 0x1003 lands on word 0
    wr(32'h0000_1003, 32'hA5A5A5A5);
    req(1'b0, 32'h0, 32'd0, 1'b0);
    check("alias_rd", data_o, 32'hA5A5A5A5);
    idle();

    wr(32'h4, 32'h44444444);
    wr(32'h8, 32'h88888888);
    wr(32'h20, 32'h0BADF00D);
    wr(32'h30, 32'h30303030);

    // aborts: mid-wait and on the edge the counter expires
    abort_req(32'h20, 32'h11111111, 1);
    check("abort1_data_kept", data_o, 32'hA5A5A5A5);
    abort_req(32'h20, 32'h11111111, 2);
    check("abort2_data_kept", data_o, 32'hA5A5A5A5);
    req(1'b0, 32'h20, 32'd0, 1'b0);
    check("abort_ram_kept", data_o, 32'h0BADF00D);
    idle();

    // back-to-back reads with select held high
    ack_log.delete();
    req(1'b0, 32'h0, 32'd0, 1'b0);
    check("b2b_rd0", data_o, 32'hA5A5A5A5);
    req(1'b0, 32'h4, 32'd0, 1'b1);
    check("b2b_rd1", data_o, 32'h44444444);
    req(1'b0, 32'h8, 32'd0, 1'b1);
    check("b2b_rd2", data_o, 32'h88888888);
    idle();
    check("b2b_ack_count", ack_log.size(), 32'd3);
    if (ack_log.size() == 3) begin
      check("b2b_spacing1", ack_log[1] - ack_log[0], WS + 2);
      check("b2b_spacing2", ack_log[2] - ack_log[1], WS + 2);
    end

    // async reset during WAIT of a write
    addr_i = 32'h30; data_i = 32'hFFFFFFFF; we_i = 1'b1; select_i = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    exp_data = 32'd0;
    #1;
    check("rst_async_ack", {31'd0, ack_o}, 32'd0);
    check("rst_async_data", data_o, 32'd0);
    select_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req(1'b0, 32'h30, 32'd0, 1'b0);
    check("rst_ram_kept", data_o, 32'h30303030);
    idle();

    // zero wait states on the second instance
    z_addr_i = 32'h4; z_data_i = 32'h12345678; z_we_i = 1'b1; z_select_i = 1'b1;
    @(negedge clk);
    check("ws0_wr_ack", {31'd0, z_ack_o}, 32'd1);
    z_select_i = 1'b0;
    @(negedge clk);
    check("ws0_ack_drop", {31'd0, z_ack_o}, 32'd0);
    z_we_i = 1'b0; z_select_i = 1'b1;
    @(negedge clk);
    check("ws0_rd_ack", {31'd0, z_ack_o}, 32'd1);
    check("ws0_rd_data", z_data_o, 32'h12345678);
    z_select_i = 1'b0;
    @(negedge clk);
    check("ws0_rd_ack_drop", {31'd0, z_ack_o}, 32'd0);
    check("ws0_rd_held", z_data_o, 32'h12345678);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
